// File: rtl/video_timing_pkg.sv
// Shared raster-timing types, default 640x480@60 segment lengths and the total-length helper.
package video_timing_pkg;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CNT_W    = 11;

    function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel enable in, sync/active/coordinates/markers out.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 11
);
    logic             pix_en;
    logic             hsync;
    logic             vsync;
    logic             active;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             sof;
    logic             eol;

    modport master (input pix_en, output hsync, vsync, active, x, y, sof, eol);
    modport slave  (output pix_en, input hsync, vsync, active, x, y, sof, eol);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping index counter plus its ACTIVE/FRONT/SYNC/BACK region state.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CNT_W  = 11
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       inc,
    output logic [CNT_W-1:0]           count,
    output video_timing_pkg::region_t  region,
    output logic                       last,
    output logic [CNT_W-1:0]           next_count_c,
    output video_timing_pkg::region_t  next_region_c
);
    localparam int unsigned TOTAL = video_timing_pkg::seg_total(ACTIVE, FP, SYNC, BP);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0 ||
        (64'(TOTAL) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_cfg
        $fatal(1, "vga_axis_counter: zero-length segment or CNT_W too narrow for total");
    end

    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

    assign last = inc && (count == LAST_IDX);

    // Region advances on the last index of the current region.
    always_comb begin
        next_count_c  = count;
        next_region_c = region;
        if (inc) begin
            next_count_c = (count == LAST_IDX) ? '0 : count + CNT_W'(1);
            case (region)
                video_timing_pkg::ACTIVE: if (count == END_ACT)  next_region_c = video_timing_pkg::FRONT;
                video_timing_pkg::FRONT:  if (count == END_FP)   next_region_c = video_timing_pkg::SYNC;
                video_timing_pkg::SYNC:   if (count == END_SYNC) next_region_c = video_timing_pkg::BACK;
                video_timing_pkg::BACK:   if (count == LAST_IDX) next_region_c = video_timing_pkg::ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= LAST_IDX;
            region <= video_timing_pkg::BACK;
        end else begin
            count  <= next_count_c;
            region <= next_region_c;
        end
    end

    function automatic video_timing_pkg::region_t region_of(input logic [CNT_W-1:0] c);
        if (c <= END_ACT)  return video_timing_pkg::ACTIVE;
        if (c <= END_FP)   return video_timing_pkg::FRONT;
        if (c <= END_SYNC) return video_timing_pkg::SYNC;
        return video_timing_pkg::BACK;
    endfunction

    a_region_matches: assert property (@(posedge clock) disable iff (!reset_n)
        region == region_of(count));
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        count <= LAST_IDX);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with zero-skew registered sync,
// active, coordinate and frame/line marker outputs.
module vga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    vga_timing_gen_if.master  vid
);
    logic [CNT_W-1:0] h_count, h_next_c, v_count, v_next_c;
    region_t          h_region, h_region_nxt_c, v_region, v_region_nxt_c;
    logic             h_last, v_last;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
    ) u_h (
        .clock(clock), .reset_n(reset_n), .inc(vid.pix_en),
        .count(h_count), .region(h_region), .last(h_last),
        .next_count_c(h_next_c), .next_region_c(h_region_nxt_c)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
    ) u_v (
        .clock(clock), .reset_n(reset_n), .inc(h_last),
        .count(v_count), .region(v_region), .last(v_last),
        .next_count_c(v_next_c), .next_region_c(v_region_nxt_c)
    );

    // Outputs decode the counters' next state so they land on the same edge as the counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vid.hsync  <= ~H_POL;
            vid.vsync  <= ~V_POL;
            vid.active <= 1'b0;
            vid.sof    <= 1'b0;
            vid.eol    <= 1'b0;
            vid.x      <= '0;
            vid.y      <= '0;
        end else if (vid.pix_en) begin
            vid.hsync  <= (h_region_nxt_c == SYNC) ? H_POL : ~H_POL;
            vid.vsync  <= (v_region_nxt_c == SYNC) ? V_POL : ~V_POL;
            vid.active <= (h_region_nxt_c == ACTIVE) && (v_region_nxt_c == ACTIVE);
            vid.sof    <= v_last;
            vid.eol    <= (h_next_c == CNT_W'(H_ACTIVE - 1)) && (v_region_nxt_c == ACTIVE);
            vid.x      <= h_next_c;
            vid.y      <= v_next_c;
        end
    end

    // Coordinates track the counters except in the post-reset parked state.
    a_coord_track: assert property (@(posedge clock) disable iff (!reset_n)
        (vid.x == h_count && vid.y == v_count) ||
        (h_region == BACK && v_region == BACK && vid.x == '0 && vid.y == '0 && !vid.sof));

endmodule
